// File: rtl/ad_cap_pkg.sv
// Shared types and constants for the AD9280 capture front end.
package ad_cap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StDone,
    StRelease
  } cap_state_e;

  localparam int unsigned AdcWidth      = 8;
  localparam int unsigned WordWidth     = 16;
  localparam int unsigned FullMarginDef = 4;

endpackage

// File: rtl/ad_sample_buf_if.sv
// Capture control, ADC input and FIFO write-side signals of the sample buffer.
interface ad_sample_buf_if;
  import ad_cap_pkg::*;

  logic [AdcWidth-1:0]  ad_data;
  logic [31:0]          sample_len;
  logic [15:0]          sample_div;
  logic                 ad_sample_req;
  logic                 ad_sample_ack;
  logic                 read_req;
  logic                 read_req_ack;
  logic [11:0]          fifo_wr_count;
  logic                 fifo_wr_en;
  logic [WordWidth-1:0] fifo_wr_data;
  logic                 overflow;
  logic [15:0]          drop_cnt;

  modport master (
    output ad_data, sample_len, sample_div, ad_sample_req, read_req, fifo_wr_count,
    input  ad_sample_ack, read_req_ack, fifo_wr_en, fifo_wr_data, overflow, drop_cnt
  );

  modport slave (
    input  ad_data, sample_len, sample_div, ad_sample_req, read_req, fifo_wr_count,
    output ad_sample_ack, read_req_ack, fifo_wr_en, fifo_wr_data, overflow, drop_cnt
  );

endinterface

// File: rtl/ad_sample_fmt.sv
// Registers the raw ADC byte and widens it to a FIFO word (signed or zero-extended).
module ad_sample_fmt
  import ad_cap_pkg::*;
#(
  parameter bit DATA_SIGNED = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AdcWidth-1:0]  ad_data_i,
  output logic [WordWidth-1:0] word_o
);

  logic [AdcWidth-1:0]  s;
  logic [WordWidth-1:0] word_d, word_q;

  always_comb begin
    // Flipping the MSB turns offset binary into two's complement.
    s = ad_data_i ^ {1'b1, {(AdcWidth-1){1'b0}}};
    if (DATA_SIGNED) begin
      word_d = {{(WordWidth-AdcWidth){s[AdcWidth-1]}}, s};
    end else begin
      word_d = {{(WordWidth-AdcWidth){1'b0}}, ad_data_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/ad_sample_buf.sv
// Capture FSM: decimates the ADC stream into the sample FIFO for a requested length,
// counting samples dropped while the FIFO is near full.
module ad_sample_buf
  import ad_cap_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4096,
  parameter int unsigned FULL_MARGIN = FullMarginDef,
  parameter bit          DATA_SIGNED = 1'b1
) (
  input logic            clk,
  input logic            rst,
  ad_sample_buf_if.slave bus
);

  localparam int unsigned FullLevel = FIFO_DEPTH - FULL_MARGIN;

  cap_state_e           state_q, state_d;
  logic [31:0]          remain_q, remain_d;
  logic [15:0]          div_reg_q, div_reg_d;
  logic [15:0]          div_cnt_q, div_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 wr_en_q, wr_en_d;
  logic [WordWidth-1:0] wr_data_q, wr_data_d;
  logic                 ack_q, ack_d;
  logic                 rd_ack_q, rd_ack_d;
  logic [WordWidth-1:0] fmt_word;
  logic                 tick;
  logic                 near_full;

  ad_sample_fmt #(
    .DATA_SIGNED (DATA_SIGNED)
  ) u_fmt (
    .clk_i     (clk),
    .rst_i     (rst),
    .ad_data_i (bus.ad_data),
    .word_o    (fmt_word)
  );

  assign tick      = (div_cnt_q == div_reg_q);
  assign near_full = 32'(bus.fifo_wr_count) >= FullLevel;

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    div_reg_d  = div_reg_q;
    div_cnt_d  = div_cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.ad_sample_req) begin
          remain_d   = bus.sample_len;
          div_reg_d  = bus.sample_div;
          div_cnt_d  = '0;
          drop_cnt_d = '0;
          overflow_d = 1'b0;
          state_d    = (bus.sample_len == 32'd0) ? StDone : StSample;
        end
      end
      StSample: begin
        if (!bus.ad_sample_req) begin
          state_d = StRelease;
        end else if (tick) begin
          // The ADC cannot be stalled, so a dropped sample still consumes length.
          div_cnt_d = '0;
          remain_d  = remain_q - 32'd1;
          if (near_full) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = fmt_word;
          end
          if (remain_q == 32'd1) state_d = StDone;
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      StDone: begin
        if (!bus.ad_sample_req) state_d = StRelease;
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    ack_d    = (state_q == StDone) && bus.ad_sample_req;
    rd_ack_d = bus.read_req && ((state_q == StSample) || (state_q == StDone));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      remain_q   <= '0;
      div_reg_q  <= '0;
      div_cnt_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      ack_q      <= 1'b0;
      rd_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      div_reg_q  <= div_reg_d;
      div_cnt_q  <= div_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      ack_q      <= ack_d;
      rd_ack_q   <= rd_ack_d;
    end
  end

  assign bus.ad_sample_ack = ack_q;
  assign bus.read_req_ack  = rd_ack_q;
  assign bus.fifo_wr_en    = wr_en_q;
  assign bus.fifo_wr_data  = wr_data_q;
  assign bus.overflow      = overflow_q;
  assign bus.drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_ad_sample_buf.sv
// Bench for ad_sample_buf: a signed and an unsigned instance checked against an
// edge-indexed model of which samples are kept, dropped and acknowledged.
module tb_ad_sample_buf;

  logic clk = 1'b0;
  logic rst;
  int   edge_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic [7:0]  ad_data;
  logic [31:0] sample_len;
  logic [15:0] sample_div;
  logic [11:0] wr_count;
  logic        read_req;
  logic        req0, req1;

  ad_sample_buf_if b0 ();
  ad_sample_buf_if b1 ();

  assign b0.ad_data       = ad_data;
  assign b0.sample_len    = sample_len;
  assign b0.sample_div    = sample_div;
  assign b0.fifo_wr_count = wr_count;
  assign b0.read_req      = read_req;
  assign b0.ad_sample_req = req0;
  assign b1.ad_data       = ad_data;
  assign b1.sample_len    = sample_len;
  assign b1.sample_div    = sample_div;
  assign b1.fifo_wr_count = wr_count;
  assign b1.read_req      = read_req;
  assign b1.ad_sample_req = req1;

  ad_sample_buf #(.DATA_SIGNED(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  ad_sample_buf #(.DATA_SIGNED(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic [1:0]  wr_en_v, ack_v, rra_v, ovf_v;
  logic [15:0] wr_data_v [2];
  logic [15:0] drop_v    [2];
  assign wr_en_v      = {b1.fifo_wr_en, b0.fifo_wr_en};
  assign ack_v        = {b1.ad_sample_ack, b0.ad_sample_ack};
  assign rra_v        = {b1.read_req_ack, b0.read_req_ack};
  assign ovf_v        = {b1.overflow, b0.overflow};
  assign wr_data_v[0] = b0.fifo_wr_data;
  assign wr_data_v[1] = b1.fifo_wr_data;
  assign drop_v[0]    = b0.drop_cnt;
  assign drop_v[1]    = b1.drop_cnt;

  int checks = 0;
  int errors = 0;

  // Input history keyed by the posedge at which the DUT sampled it.
  logic [7:0]  ad_h  [int];
  logic [11:0] cnt_h [int];
  logic        rra_h [int];

  int          got_e [$];
  logic [15:0] got_d [$];
  int          acc_e, ack_e;
  logic [15:0] obs_drop;
  logic        obs_ovf;

  function automatic logic [15:0] conv(input logic [7:0] a, input bit u);
    int v;
    if (u) v = int'(a);
    else   v = int'(a) - 128;
    return 16'(v);
  endfunction

  task automatic drive(input int e, input int acc, input int dmode, input int cmode);
    case (dmode)
      0:       ad_data = 8'(e - acc);
      1:       ad_data = 8'($urandom);
      default: ad_data = 8'h80;
    endcase
    case (cmode)
      0:       wr_count = 12'd0;
      1:       wr_count = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4092, 4095))
                                                       : 12'($urandom_range(0, 4091));
      default: wr_count = 12'd4092;
    endcase
    ad_h[e]  = ad_data;
    cnt_h[e] = wr_count;
  endtask

  // One full capture with handshake release; expectations come from the tick schedule
  // acc + k*(div+1), k = 1..len, each keeping ad_data from the edge before.
  task automatic run_cap(input bit u, input string name, input int len, input int div,
                         input int dmode, input int cmode, input int rr_drop);
    int          t, exp_n, drops;
    logic [11:0] c;
    logic [15:0] want;
    got_e.delete();
    got_d.delete();
    @(negedge clk);
    sample_len = 32'(len);
    sample_div = 16'(div);
    if (u) req1 = 1'b1;
    else   req0 = 1'b1;
    acc_e = edge_n + 1;
    ack_e = -1;
    drive(acc_e, acc_e, dmode, cmode);
    for (int i = 0; i < len * (div + 1) + 8; i++) begin
      @(negedge clk);
      rra_h[edge_n] = rra_v[u];
      if (wr_en_v[u]) begin
        got_e.push_back(edge_n);
        got_d.push_back(wr_data_v[u]);
      end
      if (ack_v[u] && ack_e < 0) ack_e = edge_n;
      if (rr_drop > 0 && edge_n + 1 == acc_e + rr_drop) read_req = 1'b0;
      drive(edge_n + 1, acc_e, dmode, cmode);
      if (ack_e >= 0) break;
    end
    obs_drop = drop_v[u];
    obs_ovf  = ovf_v[u];

    exp_n = 0;
    drops = 0;
    for (int k = 1; k <= len; k++) begin
      t = acc_e + k * (div + 1);
      c = cnt_h.exists(t) ? cnt_h[t] : 12'd0;
      if (c >= 12'd4092) begin
        drops++;
      end else begin
        want = conv(ad_h[t-1], u);
        checks++;
        if (exp_n >= got_e.size()) begin
          errors++;
          $display("FAIL %s write%0d: got none, want edge %0d data %h", name, exp_n, t, want);
        end else if (got_e[exp_n] !== t || got_d[exp_n] !== want) begin
          errors++;
          $display("FAIL %s write%0d: got edge %0d data %h, want edge %0d data %h", name, exp_n,
                   got_e[exp_n], got_d[exp_n], t, want);
        end
        exp_n++;
      end
    end
    checks++;
    if (got_e.size() != exp_n) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, got_e.size(), exp_n);
    end
    checks++;
    if (ack_e != acc_e + len * (div + 1) + 1) begin
      errors++;
      $display("FAIL %s ack_rise: got edge %0d want edge %0d", name, ack_e,
               acc_e + len * (div + 1) + 1);
    end
    checks++;
    if (obs_drop !== 16'(drops)) begin
      errors++;
      $display("FAIL %s drop_cnt: got %0d want %0d", name, obs_drop, drops);
    end
    checks++;
    if (obs_ovf !== (drops > 0)) begin
      errors++;
      $display("FAIL %s overflow: got %b want %b", name, obs_ovf, drops > 0);
    end

    @(negedge clk);
    if (u) req1 = 1'b0;
    else   req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_v[u] !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_fall: got %b want 0", name, ack_v[u]);
    end
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input bit u, input string name);
    checks++;
    if (ack_v[u] !== 1'b0 || rra_v[u] !== 1'b0 || wr_en_v[u] !== 1'b0 ||
        wr_data_v[u] !== 16'h0 || ovf_v[u] !== 1'b0 || drop_v[u] !== 16'h0) begin
      errors++;
      $display("FAIL %s outputs: got ack %b rra %b wr_en %b data %h ovf %b drop %0d, want all 0",
               name, ack_v[u], rra_v[u], wr_en_v[u], wr_data_v[u], ovf_v[u], drop_v[u]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs(1'b0, "reset_signed");
    check_idle_outputs(1'b1, "reset_unsigned");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_cap(1'b0, "basic", 16, 0, 0, 0, 0);
    checks++;
    if (got_d.size() != 16 || got_d[0] !== 16'hFF80 || got_d[15] !== 16'hFF8F ||
        got_e[15] - got_e[0] != 15) begin
      errors++;
      $display("FAIL basic_ramp: got %0d writes, want 16 consecutive FF80..FF8F", got_d.size());
    end
  endtask

  task automatic test_decim_unsigned();
    run_cap(1'b1, "decim", 4, 3, 2, 0, 0);
    checks++;
    if (got_d.size() != 4) begin
      errors++;
      $display("FAIL decim_count: got %0d want 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (got_d[i] !== 16'h0080 || (i > 0 && got_e[i] - got_e[i-1] != 4)) begin
          errors++;
          $display("FAIL decim_word%0d: got data %h, want 0080 spaced 4", i, got_d[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    run_cap(1'b0, "overflow", 10, int'($urandom_range(0, 2)), 1, 2, 0);
    checks++;
    if (got_d.size() != 0 || obs_drop !== 16'd10 || obs_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_totals: got writes %0d drop %0d ovf %b, want 0 10 1",
               got_d.size(), obs_drop, obs_ovf);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_cap(1'($urandom_range(0, 1)), "random", int'($urandom_range(1, 40)),
              int'($urandom_range(0, 4)), 1, 1, 0);
    end
  endtask

  task automatic test_abort_zero_len();
    int acc, nw;
    @(negedge clk);
    sample_len = 32'd50;
    sample_div = 16'd0;
    req0 = 1'b1;
    acc = edge_n + 1;
    drive(acc, acc, 1, 0);
    nw = 0;
    for (int i = 0; i < 40 && nw < 5; i++) begin
      @(negedge clk);
      if (wr_en_v[0]) nw++;
      if (nw < 5) drive(edge_n + 1, acc, 1, 0);
    end
    req0 = 1'b0;
    checks++;
    if (nw != 5) begin
      errors++;
      $display("FAIL abort_prefix: got %0d writes want 5", nw);
    end
    @(negedge clk);
    checks++;
    if (wr_en_v[0] !== 1'b0 || ack_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: got wr_en %b ack %b want 0 0", wr_en_v[0], ack_v[0]);
    end
    // Accepted exactly two edges after the abort only if the FSM is back in idle.
    run_cap(1'b0, "zero_len", 0, 0, 1, 0, 0);
  endtask

  task automatic test_read_handshake();
    @(negedge clk);
    read_req = 1'b1;
    run_cap(1'b0, "read", 12, 1, 1, 0, 6);
    checks++;
    if (rra_h[acc_e] !== 1'b0 || rra_h[acc_e+1] !== 1'b1 || rra_h[acc_e+5] !== 1'b1 ||
        rra_h[acc_e+6] !== 1'b0) begin
      errors++;
      $display("FAIL read_ack: got %b%b%b%b want 0110", rra_h[acc_e], rra_h[acc_e+1],
               rra_h[acc_e+5], rra_h[acc_e+6]);
    end
    read_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc, nw;
    @(negedge clk);
    sample_len = 32'd100;
    sample_div = 16'd0;
    req0 = 1'b1;
    acc = edge_n + 1;
    drive(acc, acc, 1, 0);
    nw = 0;
    for (int i = 0; i < 40 && nw < 7; i++) begin
      @(negedge clk);
      if (wr_en_v[0]) nw++;
      drive(edge_n + 1, acc, 1, 0);
    end
    rst  = 1'b1;
    req0 = 1'b0;
    #1;
    checks++;
    if (wr_en_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_wr_en: got %b want 0", wr_en_v[0]);
    end
    check_idle_outputs(1'b0, "reset_mid");
    @(negedge clk);
    checks++;
    if (wr_en_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_wr_en: got %b want 0", wr_en_v[0]);
    end
    rst = 1'b0;
    run_cap(1'b0, "after_reset", 100, 0, 1, 1, 0);
  endtask

  initial begin
    rst        = 1'b1;
    req0       = 1'b0;
    req1       = 1'b0;
    read_req   = 1'b0;
    ad_data    = 8'h00;
    sample_len = 32'd0;
    sample_div = 16'd0;
    wr_count   = 12'd0;
    test_reset();
    test_basic();
    test_decim_unsigned();
    test_overflow();
    test_abort_zero_len();
    test_read_handshake();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
